// File: rtl/comm_pkg.sv
// Shared types and helpers for the command master and its serial transmitter.
package comm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        XMIT,
        WAIT,
        GAP,
        DRAIN
    } state_t;

    localparam int unsigned GAP_W = 16;

    // Counter width that can hold values 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/UART_tx.sv
// 8N1 UART transmitter: LSB first, one start bit, one stop bit, idle-high line.
// tx_done is a single-cycle pulse after the stop bit has been held for a full bit time.
module UART_tx
    import comm_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       TX,
    output logic       tx_done
);

    localparam int unsigned BW = cnt_width(BAUD_DIV);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

    logic [9:0]    shreg;
    logic [3:0]    bit_cnt;
    logic [BW-1:0] baud_cnt;
    logic          sending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg    <= '1;
            bit_cnt  <= '0;
            baud_cnt <= '0;
            sending  <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (trmt) begin
                shreg    <= {1'b1, tx_data, 1'b0};
                bit_cnt  <= '0;
                baud_cnt <= '0;
                sending  <= 1'b1;
            end else if (sending) begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_cnt <= '0;
                    shreg    <= {1'b1, shreg[9:1]};
                    if (bit_cnt == 4'd9) begin
                        sending <= 1'b0;
                        tx_done <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                end else begin
                    baud_cnt <= baud_cnt + BW'(1);
                end
            end
        end
    end

    assign TX = shreg[0];

endmodule

// File: rtl/comm_master_n.sv
// Sends an NUM_BYTES-wide command MSB-byte-first over a UART, with optional
// idle gaps between bytes and an abort that lets the in-flight frame finish.
module comm_master_n
    import comm_pkg::*;
#(
    parameter int unsigned NUM_BYTES  = 2,
    parameter int unsigned GAP_CYCLES = 0,
    parameter int unsigned BAUD_DIV   = 434
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   send_cmd,
    input  logic [8*NUM_BYTES-1:0] cmd,
    input  logic                   abort,
    output logic                   TX,
    output logic                   busy,
    output logic                   cmd_cmplt
);

    localparam int unsigned W  = 8 * NUM_BYTES;
    localparam int unsigned CW = cnt_width(NUM_BYTES);
    localparam logic [CW-1:0]    CNT_LOAD = CW'(NUM_BYTES - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

    state_t           state, state_n;
    logic [CW-1:0]    byte_cnt, byte_cnt_n;
    logic [GAP_W-1:0] gap_cnt, gap_cnt_n;
    logic [W-1:0]     shreg, shreg_n;
    logic             trmt;
    logic             tx_done;
    logic [7:0]       tx_data;

    always_comb begin
        state_n    = state;
        byte_cnt_n = byte_cnt;
        gap_cnt_n  = gap_cnt;
        shreg_n    = shreg;
        cmd_cmplt  = 1'b0;
        unique case (state)
            IDLE: begin
                if (send_cmd) begin
                    shreg_n    = cmd;
                    byte_cnt_n = CNT_LOAD;
                    state_n    = XMIT;
                end
            end
            XMIT: begin
                state_n = abort ? DRAIN : WAIT;
            end
            // abort outranks a coincident tx_done
            WAIT: begin
                if (abort) begin
                    state_n = DRAIN;
                end else if (tx_done) begin
                    if (byte_cnt == '0) begin
                        cmd_cmplt = 1'b1;
                        state_n   = IDLE;
                    end else begin
                        shreg_n    = shreg << 8;
                        byte_cnt_n = byte_cnt - CW'(1);
                        if (GAP_CYCLES == 0) begin
                            state_n = XMIT;
                        end else begin
                            gap_cnt_n = GAP_LOAD;
                            state_n   = GAP;
                        end
                    end
                end
            end
            GAP: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (gap_cnt == '0) begin
                    state_n = XMIT;
                end else begin
                    gap_cnt_n = gap_cnt - GAP_W'(1);
                end
            end
            DRAIN: begin
                if (tx_done) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // trmt is registered from next state so it is high exactly during XMIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            byte_cnt <= '0;
            gap_cnt  <= '0;
            shreg    <= '0;
            trmt     <= 1'b0;
        end else begin
            state    <= state_n;
            byte_cnt <= byte_cnt_n;
            gap_cnt  <= gap_cnt_n;
            shreg    <= shreg_n;
            trmt     <= (state_n == XMIT);
        end
    end

    assign tx_data = shreg[W-1 -: 8];
    assign busy    = (state != IDLE);

    UART_tx #(
        .BAUD_DIV(BAUD_DIV)
    ) u_tx (
        .clk    (clk),
        .rst_n  (rst_n),
        .trmt   (trmt),
        .tx_data(tx_data),
        .TX     (TX),
        .tx_done(tx_done)
    );

endmodule
